// File: rtl/button_event_arbiter.sv
// Round-robin arbiter that turns per-button debounced pulses into a single
// handshaked event stream, with a post-acceptance lockout and sticky overflow flags.
module button_event_arbiter #(
    parameter int NUM_BTN        = 4,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int IDW            = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_pulse,
    input  logic               evt_ready,
    input  logic               ovf_clr,
    output logic               evt_valid,
    output logic [IDW-1:0]     evt_id,
    output logic [NUM_BTN-1:0] evt_ovf,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    localparam logic [IDW-1:0] LAST_IDX  = IDW'(NUM_BTN - 1);
    localparam logic [15:0]    LOCK_LAST = 16'((LOCKOUT_CYCLES > 0) ? (LOCKOUT_CYCLES - 1) : 0);
    localparam bit             HAS_LOCK  = (LOCKOUT_CYCLES > 0);

    state_t             state_r;
    logic [NUM_BTN-1:0] pend_r;
    logic [IDW-1:0]     last_grant_r;
    logic [15:0]        lock_cnt_r;

    logic               accept_s;
    logic [NUM_BTN-1:0] accept_vec_s;
    logic [NUM_BTN-1:0] pend_next_s;
    logic [NUM_BTN-1:0] new_ovf_s;
    logic [NUM_BTN-1:0] ovf_next_s;
    logic [IDW-1:0]     winner_s;
    logic               found_s;

    // Index reached k steps after base, wrapping at NUM_BTN (k is 1..NUM_BTN).
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_BTN) begin
            sum = sum - NUM_BTN;
        end else begin
            sum = sum;
        end
        return IDW'(sum);
    endfunction

    assign accept_s = (state_r == ST_PRESENT) && evt_ready;

    // Decode the accepted event into a one-hot clear mask.
    always_comb begin
        accept_vec_s = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            accept_vec_s[i] = accept_s && (evt_id == IDW'(i));
        end
    end

    // Pending/overflow next state; a pulse coinciding with its own acceptance re-queues.
    always_comb begin
        pend_next_s = (pend_r & ~accept_vec_s) | btn_pulse;
        new_ovf_s   = btn_pulse & pend_r & ~accept_vec_s;
        if (ovf_clr) begin
            ovf_next_s = new_ovf_s;
        end else begin
            ovf_next_s = evt_ovf | new_ovf_s;
        end
    end

    // Round-robin search: walk from the far end so the nearest hit after last_grant wins.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        for (int k = NUM_BTN; k >= 1; k--) begin
            winner_s = pend_r[rr_index(last_grant_r, k)] ? rr_index(last_grant_r, k) : winner_s;
            found_s  = found_s | pend_r[rr_index(last_grant_r, k)];
        end
    end

    // Pending and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r  <= '0;
            evt_ovf <= '0;
        end else begin
            pend_r  <= pend_next_s;
            evt_ovf <= ovf_next_s;
        end
    end

    // Event FSM with registered evt_valid/evt_id/busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= LAST_IDX;
            lock_cnt_r   <= 16'd0;
            evt_valid    <= 1'b0;
            evt_id       <= '0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        evt_id    <= winner_s;
                        evt_valid <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= ST_PRESENT;
                    end else begin
                        evt_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ST_PRESENT: begin
                    if (evt_ready) begin
                        last_grant_r <= evt_id;
                        evt_valid    <= 1'b0;
                        lock_cnt_r   <= 16'd0;
                        if (HAS_LOCK) begin
                            state_r <= ST_LOCKOUT;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        evt_valid <= 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (lock_cnt_r == LOCK_LAST) begin
                        lock_cnt_r <= 16'd0;
                        state_r    <= ST_IDLE;
                        busy       <= 1'b0;
                    end else begin
                        lock_cnt_r <= lock_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    lock_cnt_r <= 16'd0;
                    evt_valid  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboarded bench for button_event_arbiter: expected event IDs are queued at
// stimulus time and popped whenever the DUT completes a handshake.
module tb_button_event_arbiter;

    localparam int NB   = 4;
    localparam int LOCK = 4;
    localparam int IW   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_pulse;
    logic          evt_ready;
    logic          ovf_clr;
    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic [NB-1:0] evt_ovf;
    logic          busy;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int sb_q[$];
    int sb_exp;

    button_event_arbiter #(.NUM_BTN(NB), .LOCKOUT_CYCLES(LOCK), .IDW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .btn_pulse(btn_pulse), .evt_ready(evt_ready),
        .ovf_clr(ovf_clr), .evt_valid(evt_valid), .evt_id(evt_id),
        .evt_ovf(evt_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency/spacing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every completed handshake must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_event", 32'(evt_id), 32'hFFFF_FFFF);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sb_evt_id", 32'(evt_id), 32'(sb_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_pulse = '0;
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        sb_q.delete();
        repeat (3) step();
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (evt_valid) begin
                at = cyc;
                break;
            end
            step();
        end
        if (at < 0) check("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected finish");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        int t0, t1, bad;

        // Reset values
        do_reset();
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_id", 32'(evt_id), 32'd0);
        check("rst_ovf", 32'(evt_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single pulse latency and lockout length
        evt_ready = 1'b1;
        repeat (5) step();
        btn_pulse = 4'b0100;
        sb_q.push_back(2);
        step();
        btn_pulse = '0;
        check("lat_n1_valid", 32'(evt_valid), 32'd0);
        step();
        check("lat_n2_valid", 32'(evt_valid), 32'd1);
        check("lat_n2_id", 32'(evt_id), 32'd2);
        bad = 0;
        for (int k = 0; k < LOCK; k++) begin
            step();
            if (busy !== 1'b1 || evt_valid !== 1'b0) bad++;
        end
        check("lockout_busy", 32'(bad), 32'd0);
        step();
        check("after_lock_busy", 32'(busy), 32'd0);

        // All four buttons at once: round-robin order and spacing
        do_reset();
        evt_ready = 1'b1;
        btn_pulse = 4'b1111;
        for (int i = 0; i < NB; i++) sb_q.push_back(i);
        step();
        btn_pulse = '0;
        step();
        wait_valid(20, t0);
        for (int e = 1; e < NB; e++) begin
            step();
            wait_valid(30, t1);
            check("rr_spacing", 32'(t1 - t0), 32'(LOCK + 2));
            t0 = t1;
        end

        // Consumer stalls; repeated pulse on a pending button overflows
        do_reset();
        btn_pulse = 4'b0010;
        sb_q.push_back(1);
        step();
        btn_pulse = '0;
        wait_valid(20, t0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 3) begin
                btn_pulse = 4'b1000;
                sb_q.push_back(3);
            end else if (i == 10) begin
                btn_pulse = 4'b1000;
            end else begin
                btn_pulse = '0;
            end
            if (evt_valid !== 1'b1 || evt_id !== 2'd1) bad++;
        end
        btn_pulse = '0;
        step();
        check("stall_hold_id", 32'(bad), 32'd0);
        check("stall_ovf", 32'(evt_ovf), 32'h8);
        evt_ready = 1'b1;
        step();
        wait_valid(30, t1);
        check("stall_second_id", 32'(evt_id), 32'd3);
        bad = 0;
        for (int i = 0; i < LOCK + 6; i++) begin
            step();
            if (evt_valid) bad++;
        end
        check("stall_no_extra", 32'(bad), 32'd0);

        // Pulse in the acceptance cycle re-queues without overflow
        do_reset();
        evt_ready = 1'b1;
        btn_pulse = 4'b0001;
        sb_q.push_back(0);
        step();
        btn_pulse = '0;
        wait_valid(20, t0);
        btn_pulse = 4'b0001;
        sb_q.push_back(0);
        step();
        btn_pulse = '0;
        check("requeue_ovf", 32'(evt_ovf), 32'd0);
        wait_valid(30, t1);
        check("requeue_spacing", 32'(t1 - t0), 32'(LOCK + 2));
        step();
        check("requeue_ovf_end", 32'(evt_ovf), 32'd0);

        // Asynchronous reset in LOCKOUT drops everything
        do_reset();
        evt_ready = 1'b1;
        btn_pulse = 4'b1000;
        sb_q.push_back(3);
        step();
        btn_pulse = '0;
        wait_valid(20, t0);
        step();
        btn_pulse = 4'b0110;
        step();
        btn_pulse = '0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(evt_valid), 32'd0);
        check("async_rst_id", 32'(evt_id), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ovf", 32'(evt_ovf), 32'd0);
        repeat (2) step();
        #2 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (evt_valid || busy) bad++;
        end
        check("post_rst_idle", 32'(bad), 32'd0);

        // Overflow clear racing a new overflow
        do_reset();
        btn_pulse = 4'b0111;
        sb_q.push_back(0);
        sb_q.push_back(1);
        sb_q.push_back(2);
        step();
        btn_pulse = '0;
        wait_valid(20, t0);
        btn_pulse = 4'b0101;
        step();
        btn_pulse = '0;
        check("ovf_set", 32'(evt_ovf), 32'h5);
        btn_pulse = 4'b0010;
        ovf_clr = 1'b1;
        step();
        btn_pulse = '0;
        ovf_clr = 1'b0;
        check("ovf_clr_race", 32'(evt_ovf), 32'h2);
        evt_ready = 1'b1;
        for (int e = 0; e < 3; e++) begin
            wait_valid(30, t1);
            step();
        end
        repeat (LOCK + 4) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
